// File: rtl/tower_placer_control_if.sv
// Keypad, datapath-status and datapath-strobe bundle between the placer controller and its datapath.
// master = controller side, slave = datapath/keypad side.
interface tower_placer_control_if;
    logic key_right;
    logic key_down;
    logic key_place;
    logic valid;
    logic square_done;
    logic erase_square_done;
    logic tower_done;

    logic top_left;
    logic draw_square;
    logic move_right;
    logic move_down;
    logic move_right_wait;
    logic move_down_wait;
    logic draw_tower;
    logic erase_square_right;
    logic erase_square_down;
    logic erase_square_tower;
    logic busy;

    modport master (
        input  key_right, key_down, key_place, valid,
        input  square_done, erase_square_done, tower_done,
        output top_left, draw_square, move_right, move_down,
        output move_right_wait, move_down_wait, draw_tower,
        output erase_square_right, erase_square_down, erase_square_tower,
        output busy
    );

    modport slave (
        output key_right, key_down, key_place, valid,
        output square_done, erase_square_done, tower_done,
        input  top_left, draw_square, move_right, move_down,
        input  move_right_wait, move_down_wait, draw_tower,
        input  erase_square_right, erase_square_down, erase_square_tower,
        input  busy
    );
endinterface

// File: rtl/tower_placer_control.sv
// Cursor/tower placement sequencer: edge-detected keys feed a one-entry command slot; the FSM drives one-hot
// registered datapath strobes (valid in the first cycle of each state) and waits on datapath done/valid levels.
module tower_placer_control (
    input  logic                          clk,
    input  logic                          reset,
    tower_placer_control_if.master        bus
);

    typedef enum logic [3:0] {
        S_TOP_LEFT,
        S_DRAW_SQ,
        S_IDLE,
        S_ERASE_R,
        S_MOVE_R,
        S_MOVE_R_WAIT,
        S_ERASE_D,
        S_MOVE_D,
        S_MOVE_D_WAIT,
        S_ERASE_T,
        S_DRAW_T
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_RIGHT,
        CMD_DOWN,
        CMD_PLACE
    } cmd_t;

    typedef struct packed {
        logic top_left;
        logic draw_square;
        logic move_right;
        logic move_down;
        logic move_right_wait;
        logic move_down_wait;
        logic draw_tower;
        logic erase_square_right;
        logic erase_square_down;
        logic erase_square_tower;
    } strobe_t;

    state_t     state_q, state_next;
    cmd_t       pend_q, pend_next, edge_cmd;
    strobe_t    strb_q, strb_next;
    logic [2:0] keys, keys_q, edges;
    logic       started_q;

    assign keys  = {bus.key_place, bus.key_down, bus.key_right};
    assign edges = keys & ~keys_q;

    always_comb begin
        edge_cmd = CMD_NONE;
        if (edges[2])      edge_cmd = CMD_PLACE;
        else if (edges[1]) edge_cmd = CMD_DOWN;
        else if (edges[0]) edge_cmd = CMD_RIGHT;
    end

    always_comb begin
        state_next = state_q;
        pend_next  = (pend_q == CMD_NONE) ? edge_cmd : pend_q;
        strb_next  = '0;

        case (state_q)
            // The first cycle out of reset is spent in TOP_LEFT so its strobe is visible.
            S_TOP_LEFT:    state_next = started_q ? S_DRAW_SQ : S_TOP_LEFT;
            S_DRAW_SQ:     if (bus.square_done) state_next = S_IDLE;
            S_IDLE: begin
                case (pend_q)
                    CMD_RIGHT: state_next = S_ERASE_R;
                    CMD_DOWN:  state_next = S_ERASE_D;
                    CMD_PLACE: state_next = S_ERASE_T;
                    default:   state_next = S_IDLE;
                endcase
                if (pend_q != CMD_NONE) pend_next = CMD_NONE;
            end
            S_ERASE_R:     if (bus.erase_square_done) state_next = S_MOVE_R;
            S_MOVE_R:      if (bus.valid) state_next = S_MOVE_R_WAIT;
            S_MOVE_R_WAIT: state_next = S_DRAW_SQ;
            S_ERASE_D:     if (bus.erase_square_done) state_next = S_MOVE_D;
            S_MOVE_D:      if (bus.valid) state_next = S_MOVE_D_WAIT;
            S_MOVE_D_WAIT: state_next = S_DRAW_SQ;
            S_ERASE_T:     if (bus.erase_square_done) state_next = S_DRAW_T;
            S_DRAW_T:      if (bus.tower_done) state_next = S_DRAW_SQ;
            default:       state_next = S_TOP_LEFT;
        endcase

        // Strobes are decoded from the next state so the registered copy lines up with the state register.
        case (state_next)
            S_TOP_LEFT:    strb_next.top_left           = 1'b1;
            S_DRAW_SQ:     strb_next.draw_square        = 1'b1;
            S_ERASE_R:     strb_next.erase_square_right = 1'b1;
            S_MOVE_R:      strb_next.move_right         = 1'b1;
            S_MOVE_R_WAIT: strb_next.move_right_wait    = 1'b1;
            S_ERASE_D:     strb_next.erase_square_down  = 1'b1;
            S_MOVE_D:      strb_next.move_down          = 1'b1;
            S_MOVE_D_WAIT: strb_next.move_down_wait     = 1'b1;
            S_ERASE_T:     strb_next.erase_square_tower = 1'b1;
            S_DRAW_T:      strb_next.draw_tower         = 1'b1;
            default:       strb_next                    = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_TOP_LEFT;
            pend_q    <= CMD_NONE;
            strb_q    <= '0;
            keys_q    <= 3'b111;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_next;
            pend_q    <= pend_next;
            strb_q    <= strb_next;
            keys_q    <= keys;
            started_q <= 1'b1;
        end
    end

    assign bus.top_left           = strb_q.top_left;
    assign bus.draw_square        = strb_q.draw_square;
    assign bus.move_right         = strb_q.move_right;
    assign bus.move_down          = strb_q.move_down;
    assign bus.move_right_wait    = strb_q.move_right_wait;
    assign bus.move_down_wait     = strb_q.move_down_wait;
    assign bus.draw_tower         = strb_q.draw_tower;
    assign bus.erase_square_right = strb_q.erase_square_right;
    assign bus.erase_square_down  = strb_q.erase_square_down;
    assign bus.erase_square_tower = strb_q.erase_square_tower;
    assign bus.busy               = (state_q != S_IDLE);

endmodule
